// File: rtl/net_arb_mode_sequencer.sv
// net_arb_mode_sequencer
//   Sequences trusted/untrusted ownership changes of the network arbiter's
//   O-side AXI-Stream ports (txc, txd, rxd, rxs). A requested mode change is
//   committed only once every stream sits on a frame boundary, so no frame is
//   ever split between domains. A drain that never completes is ended by a
//   one-cycle flush pulse into the O-side stream resets.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | committed mode matches request, gates open
//   DRAIN  | switch pending, frames in progress may finish, new ones gated
//   QUIET  | all streams idle, hold off QUIET_CYCLES before committing
//   FLUSH  | drain timed out, pulse flush_n_o and drop frame tracking
//   COMMIT | latch the requested mode and count the switch
//
// Ports
//   clk, resetn      clock, synchronous active-low reset
//   req_trusted_i    requested mode (level) from the control register
//   s_tvalid_i       O-side tvalid {rxs,rxd,txd,txc}
//   s_tready_i       O-side tready {rxs,rxd,txd,txc}
//   s_tlast_i        O-side tlast  {rxs,rxd,txd,txc}
//   trusted_o        committed mode to the arbiter mux
//   gate_o           1 = mux blocks new frames on that stream
//   flush_n_o        active-low flush pulse into the O-side aresetn
//   busy_o           1 while a switch is in progress
//   timeout_err_o    sticky, set by a forced flush
//   switch_count_o   committed switches, wrapping

module net_arb_mode_sequencer #(
  parameter bit RESET_TRUSTED = 1'b1,
  parameter int QUIET_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_trusted_i,
  input  logic [3:0]       s_tvalid_i,
  input  logic [3:0]       s_tready_i,
  input  logic [3:0]       s_tlast_i,
  output logic             trusted_o,
  output logic [3:0]       gate_o,
  output logic             flush_n_o,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] switch_count_o
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_QUIET,
    S_FLUSH,
    S_COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       inflight_q, inflight_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
  logic             trusted_q, trusted_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       gate_q, gate_d;
  logic             busy_q, flush_n_q;
  logic [3:0]       beat;
  logic             want_switch;

  // Frame tracking. A flush resets the O-side streams, so any partial frame
  // is gone and tracking restarts from empty.
  always_comb begin
    beat       = s_tvalid_i & s_tready_i;
    inflight_d = inflight_q;
    for (int i = 0; i < 4; i++) begin
      if (beat[i]) inflight_d[i] = ~s_tlast_i[i];
    end
    if (state_q == S_FLUSH) inflight_d = '0;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    trusted_d   = trusted_q;
    err_d       = err_q;
    count_d     = count_q;
    want_switch = (req_trusted_i != trusted_q);
    case (state_q)
      S_IDLE: begin
        if (want_switch) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        // Idle streams take priority over the timeout hitting in the same cycle.
        if (!want_switch) begin
          state_d = S_IDLE;
        end else if (inflight_q == 4'h0) begin
          state_d     = S_QUIET;
          quiet_cnt_d = QW'(QUIET_CYCLES - 1);
        end else if (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
          state_d = S_FLUSH;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_QUIET: begin
        // A beat under gate is a protocol violation upstream; go back to
        // draining but keep the accumulated drain time so the timeout still
        // bounds the whole switch.
        if (!want_switch) begin
          state_d = S_IDLE;
        end else if (|beat) begin
          state_d = S_DRAIN;
        end else if (quiet_cnt_q == '0) begin
          state_d = S_COMMIT;
        end else begin
          quiet_cnt_d = quiet_cnt_q - 1'b1;
        end
      end
      S_FLUSH: begin
        err_d   = 1'b1;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (want_switch) begin
          trusted_d = req_trusted_i;
          count_d   = count_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the mux sees clean levels.
  always_comb begin
    case (state_d)
      S_IDLE:           gate_d = 4'h0;
      S_DRAIN, S_QUIET: gate_d = ~inflight_d;
      default:          gate_d = 4'hF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      inflight_q  <= '0;
      drain_cnt_q <= '0;
      quiet_cnt_q <= '0;
      trusted_q   <= RESET_TRUSTED;
      err_q       <= 1'b0;
      count_q     <= '0;
      gate_q      <= 4'h0;
      busy_q      <= 1'b0;
      flush_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      drain_cnt_q <= drain_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      trusted_q   <= trusted_d;
      err_q       <= err_d;
      count_q     <= count_d;
      gate_q      <= gate_d;
      busy_q      <= (state_d != S_IDLE);
      flush_n_q   <= (state_d != S_FLUSH);
    end
  end

  assign trusted_o      = trusted_q;
  assign gate_o         = gate_q;
  assign flush_n_o      = flush_n_q;
  assign busy_o         = busy_q;
  assign timeout_err_o  = err_q;
  assign switch_count_o = count_q;

endmodule

// File: tb/tb_net_arb_mode_sequencer.sv
// tb_net_arb_mode_sequencer
//   Self-checking bench: a vector table for reset and an idle switch, directed
//   sequences for drain, withdrawal, timeout and reset mid-switch, then random
//   traffic against a behavioural model of the switch rules.

module tb_net_arb_mode_sequencer;

  localparam int QC = 4;
  localparam int DT = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req = 1'b1;
  logic [3:0]    tv = 4'h0, tr = 4'h0, tl = 4'h0;
  logic          trusted, flush_n, busy, terr;
  logic [3:0]    gate;
  logic [CW-1:0] scount;

  net_arb_mode_sequencer #(
    .RESET_TRUSTED(1'b1), .QUIET_CYCLES(QC), .DRAIN_TIMEOUT(DT), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .resetn(resetn), .req_trusted_i(req),
    .s_tvalid_i(tv), .s_tready_i(tr), .s_tlast_i(tl),
    .trusted_o(trusted), .gate_o(gate), .flush_n_o(flush_n), .busy_o(busy),
    .timeout_err_o(terr), .switch_count_o(scount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at that point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit        m_tr;
  int        m_cnt;
  bit        m_err;
  bit [3:0]  m_inf;
  string     m_phase;
  int        m_age;
  int        m_left;

  function automatic logic [3:0] m_gate();
    if (m_phase == "idle") return 4'h0;
    if (m_phase == "flush" || m_phase == "commit") return 4'hF;
    return ~m_inf;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit [3:0] beats;
    bit [3:0] nxt_inf;
    bit       pending;
    beats = tv & tr;
    if (!resetn) begin
      m_tr = 1'b1; m_cnt = 0; m_err = 1'b0; m_inf = 4'h0; m_phase = "idle";
      return;
    end
    pending = (req != m_tr);
    nxt_inf = m_inf;
    for (int i = 0; i < 4; i++) if (beats[i]) nxt_inf[i] = !tl[i];
    if (m_phase == "idle") begin
      if (pending) begin m_phase = "drain"; m_age = 0; end
    end else if (m_phase == "drain") begin
      if (!pending) m_phase = "idle";
      else if (m_inf == 4'h0) begin m_phase = "quiet"; m_left = QC - 1; end
      else if (m_age == DT - 1) m_phase = "flush";
      else m_age++;
    end else if (m_phase == "quiet") begin
      if (!pending) m_phase = "idle";
      else if (beats != 4'h0) m_phase = "drain";
      else if (m_left == 0) m_phase = "commit";
      else m_left--;
    end else if (m_phase == "flush") begin
      m_err = 1'b1;
      nxt_inf = 4'h0;
      m_phase = "commit";
    end else begin
      if (pending) begin m_tr = req; m_cnt = (m_cnt + 1) % (1 << CW); end
      m_phase = "idle";
    end
    m_inf = nxt_inf;
  endtask

  task automatic compare_model();
    chk("rnd_trusted", trusted, m_tr);
    chk("rnd_gate",    gate,    m_gate());
    chk("rnd_busy",    busy,    m_phase != "idle");
    chk("rnd_flush_n", flush_n, m_phase != "flush");
    chk("rnd_err",     terr,    m_err);
    chk("rnd_count",   scount,  m_cnt);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       rst_n;
    bit       rq;
    bit [3:0] v, r, l;
    bit       e_tr;
    bit [3:0] e_gate;
    bit       e_busy;
    bit       e_fln;
    int       e_cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    // reset held two clocks, then idle, then an idle-stream switch 1 -> 0:
    // DRAIN, four QUIET cycles, COMMIT, new mode visible six edges after
    // the request
    vecs.push_back('{0, 1, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 1, 0});
    vecs.push_back('{0, 1, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 1, 0});
    vecs.push_back('{1, 1, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 1, 0});
    for (int k = 0; k < 6; k++)
      vecs.push_back('{1, 0, 4'h0, 4'hF, 4'h0, 1, 4'hF, 1, 1, 0});
    vecs.push_back('{1, 0, 4'h0, 4'hF, 4'h0, 0, 4'h0, 0, 1, 1});
    vecs.push_back('{1, 0, 4'h0, 4'hF, 4'h0, 0, 4'h0, 0, 1, 1});

    for (int k = 0; k < vecs.size(); k++) begin
      resetn = vecs[k].rst_n; req = vecs[k].rq;
      tv = vecs[k].v; tr = vecs[k].r; tl = vecs[k].l;
      step();
      chk($sformatf("vec%0d_trusted", k), trusted, vecs[k].e_tr);
      chk($sformatf("vec%0d_gate", k),    gate,    vecs[k].e_gate);
      chk($sformatf("vec%0d_busy", k),    busy,    vecs[k].e_busy);
      chk($sformatf("vec%0d_flush_n", k), flush_n, vecs[k].e_fln);
      chk($sformatf("vec%0d_count", k),   scount,  vecs[k].e_cnt);
      if (k < 2) chk($sformatf("vec%0d_err", k), terr, 0);
    end

    // ---- in-flight drain: txd has 3 beats of an open frame (mode now 0) ----
    tv = 4'h2; tr = 4'h2; tl = 4'h0;
    repeat (3) step();
    chk("t3_idle_gate", gate, 4'h0);
    tv = 4'h0; tr = 4'h0; req = 1'b1;
    step();
    chk("t3_drain_busy", busy, 1);
    chk("t3_drain_gate", gate, 4'hD);
    repeat (4) step();
    chk("t3_hold_gate", gate, 4'hD);
    chk("t3_hold_trusted", trusted, 0);
    tv = 4'h2; tr = 4'h2; tl = 4'h2;
    step();
    tv = 4'h0; tr = 4'h0; tl = 4'h0;
    n = 0;
    while (trusted == 1'b0 && n < 20) begin step(); n++; end
    chk("t3_flip_latency", n, 6);
    chk("t3_count", scount, 2);

    // ---- withdrawal during QUIET ----
    req = 1'b0;
    repeat (3) step();
    chk("t4_quiet_busy", busy, 1);
    req = 1'b1;
    step();
    chk("t4_busy", busy, 0);
    chk("t4_gate", gate, 4'h0);
    repeat (8) step();
    chk("t4_trusted", trusted, 1);
    chk("t4_count", scount, 2);
    chk("t4_err", terr, 0);

    // ---- timeout: rxd stuck mid-frame ----
    tv = 4'h4; tr = 4'h4; tl = 4'h0;
    step();
    tv = 4'h0; tr = 4'h0; req = 1'b0;
    step();
    chk("t5_drain_gate", gate, 4'hB);
    n = 1;
    while (flush_n == 1'b1 && n < 40) begin step(); n++; end
    chk("t5_flush_at", n, DT + 1);
    chk("t5_flush_gate", gate, 4'hF);
    chk("t5_flush_trusted", trusted, 1);
    step();
    chk("t5_flush_width", flush_n, 1);
    chk("t5_err", terr, 1);
    chk("t5_commit_trusted", trusted, 1);
    step();
    chk("t5_trusted", trusted, 0);
    chk("t5_count", scount, 3);
    chk("t5_busy", busy, 0);

    // ---- reset in DRAIN ----
    tv = 4'h1; tr = 4'h1; tl = 4'h0;
    step();
    tv = 4'h0; tr = 4'h0; req = 1'b1;
    step();
    chk("t6_drain_gate", gate, 4'hE);
    resetn = 1'b0;
    step();
    chk("t6_trusted", trusted, 1);
    chk("t6_busy", busy, 0);
    chk("t6_flush_n", flush_n, 1);
    chk("t6_count", scount, 0);
    chk("t6_err", terr, 0);
    chk("t6_gate", gate, 4'h0);

    // ---- random traffic against the model ----
    req = 1'b1; tv = 4'h0; tr = 4'h0; tl = 4'h0;
    model_step();
    step();
    compare_model();
    resetn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] mask;
      resetn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 24) == 0) req = ~req;
      mask = ($urandom_range(0, 9) < 7) ? ~m_gate() : 4'hF;
      tv = 4'($urandom) & mask;
      tr = 4'($urandom);
      for (int i = 0; i < 4; i++) tl[i] = ($urandom_range(0, 2) == 0);
      model_step();
      step();
      compare_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
